dd_mcu_bus_glue: RTL and testbench
==================================

Name: dd_mcu_bus_glue

Overview:
- Bus and memory glue around a 6801-class MCU core (core is external; this block drives its bus-side signals) in the Double Dragon sub-system.
- Provides address decoding, internal RAM, a dual-access 512-byte shared RAM arbitrated between main CPU and MCU, port registers, an edge-latched NMI, and ROM wait-state clock gating.

Parameters:
- none (all sizes fixed: shared RAM 512x8, internal RAM 256x8, 32 port bytes)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cen6  in  1  MCU base clock enable
- cpu_AB  in  9  main CPU address into shared RAM
- cpu_wrn  in  1  main CPU write strobe, active-low
- cpu_dout  in  8  main CPU write data
- com_cs  in  1  main CPU shared-RAM select
- shared_dout  out  8  shared RAM read data (to main CPU and MCU mux)
- mcu_ban  out  1  MCU owns shared RAM (= mcu_vma)
- mcu_nmi_set  in  1  rising edge requests MCU NMI
- mcu_irqmain  out  1  IRQ to main CPU (= port6 bit1)
- rom_addr  out  14  MCU ROM address (= mcu_addr[13:0])
- rom_data  in  8  ROM data
- rom_cs  out  1  ROM access active
- rom_ok  in  1  ROM data valid
- mcu_addr  in  16  core address
- mcu_vma  in  1  core valid memory address
- mcu_rnw  in  1  core read(1)/write(0)
- mcu_dout  in  8  core write data
- mcu_din  out  8  core read data
- mcu_nmi  out  1  NMI to core
- mcu_cen  out  1  core clock enable

Behaviour:
- Decode (all 0 when mcu_vma=0), combinational: rom_cs when A[15:14]=11; ram_cs when 0x0040<=A<0x0140; shared_cs when A[15:12]=8; port_cs when A<0x0028.
- mcu_din priority: ram_cs -> internal RAM q; else shared_cs -> shared_dout; else port_cs -> port byte A[4:0]; else rom_data.
- Shared RAM: single port, sync. On posedge clk with cen6: if we, mem[addr]<=data; q<=mem[addr] (old data on write; 1-cycle read latency). Mux: mcu_vma=1 -> addr=A[8:0], data=mcu_dout, we=~mcu_rnw&shared_cs; else addr=cpu_AB, data=cpu_dout, we=~cpu_wrn&com_cs. Contents not reset.
- Internal RAM: 256x8, same sync semantics, enable mcu_cen, addr A[7:0] (0x100-0x13F alias 0x00-0x3F), we=ram_cs&~mcu_rnw.
- Ports: 32-byte array, written at A[4:0] when port_cs & ~mcu_rnw & mcu_cen; array not reset. Port6 register p6 at A[5:0]=0x17, same write condition, reset 0x00. mcu_irqmain=p6[1].
- NMI latch: registered previous of mcu_nmi_set; reset q=0, prev=0. Each clk: if nmi_clr (=~p6[0]) q<=0; else if mcu_nmi_set & ~prev q<=1. Clear has priority; after reset NMI is masked until firmware sets p6[0]=1. Latch clears when firmware writes p6[0]=0. mcu_nmi=q.
- Wait: waitn updated on negedge clk, reset 1. If rom_cs & ~rom_ok -> 0; else if rom_ok -> 1; else hold. mcu_cen = cen6 & (waitn | rst).
- mcu_ban = mcu_vma; rom_addr = mcu_addr[13:0].
- Simultaneous CPU and MCU shared writes: MCU wins when mcu_vma=1; CPU write is dropped.

Test Plan:
- Reset -> mcu_irqmain=0, mcu_nmi=0, waitn=1, mcu_cen follows cen6.
- MCU writes 0x03 to 0x0017 -> mcu_irqmain=1; pulse mcu_nmi_set -> mcu_nmi=1 next clk; write 0x02 -> mcu_nmi=0; with p6[0]=0 further pulses leave mcu_nmi=0.
- mcu_vma=0, CPU writes 0xA5 at cpu_AB=0x123 (com_cs, cpu_wrn=0, cen6) -> MCU read 0x8123 returns 0xA5 on mcu_din one cen6 cycle later.
- MCU writes 0x5A to 0x0080, reads back 0x0080 -> 0x5A; read 0x0140 -> rom_data selected.
- MCU reads 0xC000 with rom_ok=0 -> rom_cs=1, mcu_cen held 0 until rom_ok=1, then resumes; rom_addr=0x0000.
- MCU writes 0x77 to port 0x0003 -> read 0x0003 returns 0x77; p6 unchanged.

Source files
------------

// File: rtl/dd_mcu_bus_glue.sv
// Bus glue for the Double Dragon sub-CPU MCU: address decode, internal and shared RAM,
// port registers, edge-latched NMI and ROM wait-state clock gating.
module dd_mcu_bus_glue (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic [8:0]  cpu_AB,
  input  logic        cpu_wrn,
  input  logic [7:0]  cpu_dout,
  input  logic        com_cs,
  output logic [7:0]  shared_dout,
  output logic        mcu_ban,
  input  logic        mcu_nmi_set,
  output logic        mcu_irqmain,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [15:0] mcu_addr,
  input  logic        mcu_vma,
  input  logic        mcu_rnw,
  input  logic [7:0]  mcu_dout,
  output logic [7:0]  mcu_din,
  output logic        mcu_nmi,
  output logic        mcu_cen
);

  localparam int unsigned DW       = 8;
  localparam int unsigned SH_AW    = 9;
  localparam int unsigned RAM_AW   = 8;
  localparam int unsigned PORT_AW  = 5;
  localparam int unsigned SH_DEPTH   = 1 << SH_AW;
  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned PORT_DEPTH = 1 << PORT_AW;

  logic          ram_cs;
  logic          shared_cs;
  logic          port_cs;
  logic          waitn;
  logic [DW-1:0] p6;
  logic [DW-1:0] ram_q;
  logic          nmi_prev;

  logic [SH_AW-1:0] sh_addr;
  logic [DW-1:0]    sh_data;
  logic             sh_we;
  logic             ram_we;
  logic             port_we;

  logic [DW-1:0] sh_mem   [SH_DEPTH];
  logic [DW-1:0] ram_mem  [RAM_DEPTH];
  logic [DW-1:0] port_mem [PORT_DEPTH];

  // Address decode, all selects gated by a valid core cycle
  assign rom_cs    = mcu_vma & (mcu_addr[15:14] == 2'b11);
  assign ram_cs    = mcu_vma & (mcu_addr >= 16'h0040) & (mcu_addr < 16'h0140);
  assign shared_cs = mcu_vma & (mcu_addr[15:12] == 4'h8);
  assign port_cs   = mcu_vma & (mcu_addr < 16'h0028);

  assign mcu_ban     = mcu_vma;
  assign rom_addr    = mcu_addr[13:0];
  assign mcu_irqmain = p6[1];
  assign mcu_cen     = cen6 & (waitn | rst);

  always_comb begin
    mcu_din = rom_data;
    if (ram_cs)         mcu_din = ram_q;
    else if (shared_cs) mcu_din = shared_dout;
    else if (port_cs)   mcu_din = port_mem[mcu_addr[PORT_AW-1:0]];
  end

  // Shared RAM port mux: MCU owns the RAM whenever it has a valid cycle
  always_comb begin
    sh_addr = cpu_AB;
    sh_data = cpu_dout;
    sh_we   = ~cpu_wrn & com_cs;
    if (mcu_vma) begin
      sh_addr = mcu_addr[SH_AW-1:0];
      sh_data = mcu_dout;
      sh_we   = ~mcu_rnw & shared_cs;
    end
  end

  always_ff @(posedge clk) begin
    if (cen6) begin
      if (sh_we) sh_mem[sh_addr] <= sh_data;
      shared_dout <= sh_mem[sh_addr];
    end
  end

  // Internal RAM; 0x100-0x13F wraps onto locations 0x00-0x3F
  assign ram_we = ram_cs & ~mcu_rnw;

  always_ff @(posedge clk) begin
    if (mcu_cen) begin
      if (ram_we) ram_mem[mcu_addr[RAM_AW-1:0]] <= mcu_dout;
      ram_q <= ram_mem[mcu_addr[RAM_AW-1:0]];
    end
  end

  assign port_we = port_cs & ~mcu_rnw & mcu_cen;

  always_ff @(posedge clk) begin
    if (port_we) port_mem[mcu_addr[PORT_AW-1:0]] <= mcu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p6 <= '0;
    end else if (port_we && mcu_addr[5:0] == 6'h17) begin
      p6 <= mcu_dout;
    end
  end

  // NMI edge latch; p6[0]=0 holds it cleared, so NMI is masked out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_prev <= 1'b0;
      mcu_nmi  <= 1'b0;
    end else begin
      nmi_prev <= mcu_nmi_set;
      if (!p6[0])                        mcu_nmi <= 1'b0;
      else if (mcu_nmi_set && !nmi_prev) mcu_nmi <= 1'b1;
    end
  end

  // ROM wait state, sampled on the falling edge so the core stalls before its next rising edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      waitn <= 1'b1;
    end else if (rom_cs && !rom_ok) begin
      waitn <= 1'b0;
    end else if (rom_ok) begin
      waitn <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dd_mcu_bus_glue.sv
// Directed self-checking bench for dd_mcu_bus_glue.
module tb_dd_mcu_bus_glue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen6;
  logic [8:0]  cpu_AB;
  logic        cpu_wrn;
  logic [7:0]  cpu_dout;
  logic        com_cs;
  logic [7:0]  shared_dout;
  logic        mcu_ban;
  logic        mcu_nmi_set;
  logic        mcu_irqmain;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_cs;
  logic        rom_ok;
  logic [15:0] mcu_addr;
  logic        mcu_vma;
  logic        mcu_rnw;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic        mcu_nmi;
  logic        mcu_cen;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dd_mcu_bus_glue dut (
    .clk(clk), .rst(rst), .cen6(cen6),
    .cpu_AB(cpu_AB), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .com_cs(com_cs),
    .shared_dout(shared_dout), .mcu_ban(mcu_ban), .mcu_nmi_set(mcu_nmi_set),
    .mcu_irqmain(mcu_irqmain), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .mcu_addr(mcu_addr), .mcu_vma(mcu_vma),
    .mcu_rnw(mcu_rnw), .mcu_dout(mcu_dout), .mcu_din(mcu_din),
    .mcu_nmi(mcu_nmi), .mcu_cen(mcu_cen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcu_write(input logic [15:0] a, input logic [7:0] d);
    mcu_vma = 1'b1; mcu_rnw = 1'b0; mcu_addr = a; mcu_dout = d;
    tick();
    mcu_vma = 1'b0; mcu_rnw = 1'b1;
  endtask

  task automatic mcu_read(input logic [15:0] a, output logic [7:0] d);
    mcu_vma = 1'b1; mcu_rnw = 1'b1; mcu_addr = a;
    tick();
    d = mcu_din;
    mcu_vma = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    cpu_AB = a; cpu_dout = d; com_cs = 1'b1; cpu_wrn = 1'b0;
    tick();
    com_cs = 1'b0; cpu_wrn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen6 = 1'b1; cpu_AB = '0; cpu_wrn = 1'b1; cpu_dout = '0; com_cs = 1'b0;
    mcu_nmi_set = 1'b0; rom_data = 8'hE7; rom_ok = 1'b1; mcu_addr = '0;
    mcu_vma = 1'b0; mcu_rnw = 1'b1; mcu_dout = '0;
    #1;
    vectors++; if (mcu_cen !== 1'b1) begin errors++; $display("FAIL rst_cen_hi: got %b expected 1", mcu_cen); end
    vectors++; if (mcu_irqmain !== 1'b0) begin errors++; $display("FAIL rst_irqmain: got %b expected 0", mcu_irqmain); end
    vectors++; if (mcu_nmi !== 1'b0) begin errors++; $display("FAIL rst_nmi: got %b expected 0", mcu_nmi); end
    cen6 = 1'b0; #1;
    vectors++; if (mcu_cen !== 1'b0) begin errors++; $display("FAIL rst_cen_lo: got %b expected 0", mcu_cen); end
    cen6 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++; if (mcu_cen !== 1'b1) begin errors++; $display("FAIL post_rst_cen: got %b expected 1", mcu_cen); end
  endtask

  task automatic test_nmi();
    mcu_nmi_set = 1'b1; tick(); mcu_nmi_set = 1'b0; tick();
    vectors++; if (mcu_nmi !== 1'b0) begin errors++; $display("FAIL nmi_masked_rst: got %b expected 0", mcu_nmi); end
    mcu_write(16'h0017, 8'h03);
    vectors++; if (mcu_irqmain !== 1'b1) begin errors++; $display("FAIL irqmain_set: got %b expected 1", mcu_irqmain); end
    mcu_nmi_set = 1'b1; tick();
    vectors++; if (mcu_nmi !== 1'b1) begin errors++; $display("FAIL nmi_edge: got %b expected 1", mcu_nmi); end
    mcu_nmi_set = 1'b0; tick();
    vectors++; if (mcu_nmi !== 1'b1) begin errors++; $display("FAIL nmi_hold: got %b expected 1", mcu_nmi); end
    mcu_write(16'h0017, 8'h02);
    tick();
    vectors++; if (mcu_nmi !== 1'b0) begin errors++; $display("FAIL nmi_clear: got %b expected 0", mcu_nmi); end
    vectors++; if (mcu_irqmain !== 1'b1) begin errors++; $display("FAIL irqmain_keep: got %b expected 1", mcu_irqmain); end
    mcu_nmi_set = 1'b1; tick(); mcu_nmi_set = 1'b0; tick();
    vectors++; if (mcu_nmi !== 1'b0) begin errors++; $display("FAIL nmi_masked: got %b expected 0", mcu_nmi); end
  endtask

  task automatic test_shared();
    logic [7:0] d;
    cpu_write(9'h123, 8'hA5);
    mcu_read(16'h8123, d);
    vectors++; if (d !== 8'hA5) begin errors++; $display("FAIL sh_cpu_to_mcu: got %h expected a5", d); end
    mcu_write(16'h8010, 8'h3C);
    cpu_AB = 9'h010; tick();
    vectors++; if (shared_dout !== 8'h3C) begin errors++; $display("FAIL sh_mcu_to_cpu: got %h expected 3c", shared_dout); end
    // simultaneous writes to the same location: MCU value must stick
    cpu_AB = 9'h020; cpu_dout = 8'h22; com_cs = 1'b1; cpu_wrn = 1'b0;
    mcu_write(16'h8020, 8'h11);
    com_cs = 1'b0; cpu_wrn = 1'b1;
    mcu_read(16'h8020, d);
    vectors++; if (d !== 8'h11) begin errors++; $display("FAIL sh_collide: got %h expected 11", d); end
    // CPU write while MCU holds the bus on another region is dropped
    cpu_write(9'h021, 8'h44);
    cpu_AB = 9'h021; cpu_dout = 8'h99; com_cs = 1'b1; cpu_wrn = 1'b0;
    mcu_read(16'h0080, d);
    com_cs = 1'b0; cpu_wrn = 1'b1;
    mcu_read(16'h8021, d);
    vectors++; if (d !== 8'h44) begin errors++; $display("FAIL sh_cpu_dropped: got %h expected 44", d); end
    // no write without cen6
    cpu_write(9'h030, 8'h55);
    cen6 = 1'b0; cpu_write(9'h030, 8'h66); cen6 = 1'b1;
    mcu_read(16'h8030, d);
    vectors++; if (d !== 8'h55) begin errors++; $display("FAIL sh_cen6_gate: got %h expected 55", d); end
  endtask

  task automatic test_ram();
    logic [7:0] d;
    mcu_write(16'h0080, 8'h5A);
    mcu_read(16'h0080, d);
    vectors++; if (d !== 8'h5A) begin errors++; $display("FAIL ram_rw: got %h expected 5a", d); end
    mcu_write(16'h013F, 8'h9A);
    mcu_write(16'h0040, 8'h12);
    mcu_read(16'h013F, d);
    vectors++; if (d !== 8'h9A) begin errors++; $display("FAIL ram_top: got %h expected 9a", d); end
    mcu_read(16'h0040, d);
    vectors++; if (d !== 8'h12) begin errors++; $display("FAIL ram_bottom: got %h expected 12", d); end
    rom_data = 8'hE7;
    mcu_read(16'h0140, d);
    vectors++; if (d !== 8'hE7) begin errors++; $display("FAIL ram_above: got %h expected e7", d); end
    rom_data = 8'hD4;
    mcu_read(16'h003F, d);
    vectors++; if (d !== 8'hD4) begin errors++; $display("FAIL ram_gap: got %h expected d4", d); end
  endtask

  task automatic test_rom_wait();
    rom_ok = 1'b0; rom_data = 8'h3C;
    mcu_vma = 1'b1; mcu_rnw = 1'b1; mcu_addr = 16'hC000;
    #1;
    vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL rom_cs: got %b expected 1", rom_cs); end
    vectors++; if (rom_addr !== 14'h0000) begin errors++; $display("FAIL rom_addr0: got %h expected 0000", rom_addr); end
    vectors++; if (mcu_ban !== 1'b1) begin errors++; $display("FAIL ban: got %b expected 1", mcu_ban); end
    @(negedge clk); #1;
    vectors++; if (mcu_cen !== 1'b0) begin errors++; $display("FAIL rom_stall: got %b expected 0", mcu_cen); end
    tick(); tick();
    vectors++; if (mcu_cen !== 1'b0) begin errors++; $display("FAIL rom_stall_hold: got %b expected 0", mcu_cen); end
    rom_ok = 1'b1;
    @(negedge clk); #1;
    vectors++; if (mcu_cen !== 1'b1) begin errors++; $display("FAIL rom_resume: got %b expected 1", mcu_cen); end
    vectors++; if (mcu_din !== 8'h3C) begin errors++; $display("FAIL rom_din: got %h expected 3c", mcu_din); end
    mcu_addr = 16'hFFFF; #1;
    vectors++; if (rom_addr !== 14'h3FFF) begin errors++; $display("FAIL rom_addr_top: got %h expected 3fff", rom_addr); end
    mcu_vma = 1'b0; #1;
    vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rom_cs_vma0: got %b expected 0", rom_cs); end
    tick();
  endtask

  task automatic test_ports();
    logic [7:0] d;
    mcu_write(16'h0003, 8'h77);
    mcu_read(16'h0003, d);
    vectors++; if (d !== 8'h77) begin errors++; $display("FAIL port_rw: got %h expected 77", d); end
    vectors++; if (mcu_irqmain !== 1'b1) begin errors++; $display("FAIL port_p6_keep: got %b expected 1", mcu_irqmain); end
    mcu_write(16'h0027, 8'hAB);
    mcu_read(16'h0007, d);
    vectors++; if (d !== 8'hAB) begin errors++; $display("FAIL port_alias: got %h expected ab", d); end
    rom_data = 8'h6E;
    mcu_read(16'h0028, d);
    vectors++; if (d !== 8'h6E) begin errors++; $display("FAIL port_edge: got %h expected 6e", d); end
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_shared();
    test_ram();
    test_rom_wait();
    test_ports();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
